// File: rtl/agc_cdu_counter_if_if.sv
// Signal bundle between the AGC/host side and the CDU counter interface block.
// master drives pulses and host writes; slave is the counter block itself.
interface agc_cdu_counter_if_if;
  logic        ATpPGH;
  logic        ATmPGH;
  logic        mode_we;
  logic [2:0]  mode_wdata;
  logic        cnt_we;
  logic [14:0] cnt_wdata;
  logic        CLOCKH;
  logic        AGCCA;
  logic        AGCZ;
  logic        AGCEEC;
  logic [14:0] cnt;
  logic        pend_err;

  modport master (
    output ATpPGH, ATmPGH, mode_we, mode_wdata, cnt_we, cnt_wdata,
    input  CLOCKH, AGCCA, AGCZ, AGCEEC, cnt, pend_err
  );

  modport slave (
    input  ATpPGH, ATmPGH, mode_we, mode_wdata, cnt_we, cnt_wdata,
    output CLOCKH, AGCCA, AGCZ, AGCEEC, cnt, pend_err
  );
endinterface

// File: rtl/agc_cdu_counter_if.sv
// AGC-side CDU interface: CLOCKH generation, moding discretes, and a 15-bit angle
// counter fed by synchronised ATpPGH/ATmPGH pulses through a signed pending register.
module agc_cdu_counter_if #(
  parameter int unsigned CLKH_DIV = 2000,
  parameter int unsigned CLKH_LOW = 301,
  parameter int unsigned MCT_DIV  = 1200,
  parameter int unsigned PEND_W   = 4
) (
  input logic              clk,
  input logic              rst,
  agc_cdu_counter_if_if.slave bus
);

  localparam int unsigned DivW  = $clog2(CLKH_DIV);
  localparam int unsigned TickW = $clog2(MCT_DIV);
  localparam int unsigned PW    = PEND_W + 2;

  localparam logic signed [PW-1:0] One    = PW'(1);
  localparam logic signed [PW-1:0] PendHi = PW'((2 ** (PEND_W - 1)) - 1);
  localparam logic signed [PW-1:0] PendLo = PW'(-(2 ** (PEND_W - 1)));

  logic [DivW-1:0]          div_q, div_d;
  logic [TickW-1:0]         tick_q, tick_d;
  logic                     clockh_q, clockh_d;
  logic [2:0]               mode_q, mode_d;   // {AGCEEC, AGCZ, AGCCA}
  logic [2:0]               sync_p_q, sync_p_d;
  logic [2:0]               sync_m_q, sync_m_d;
  logic [14:0]              cnt_q, cnt_d;
  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic                     err_q, err_d;

  logic                 tick, p_edge, m_edge, zero, service, ovf;
  logic signed [PW-1:0] pend_ext, edge_dt, tick_dt, pend_sum, pend_keep;

  always_comb begin
    div_d    = (div_q == DivW'(CLKH_DIV - 1)) ? '0 : div_q + DivW'(1);
    clockh_d = (div_q >= DivW'(CLKH_LOW));

    tick   = (tick_q == TickW'(MCT_DIV - 1));
    tick_d = tick ? '0 : tick_q + TickW'(1);

    mode_d   = bus.mode_we ? bus.mode_wdata : mode_q;
    zero     = ~mode_q[1];

    sync_p_d = {sync_p_q[1:0], bus.ATpPGH};
    sync_m_d = {sync_m_q[1:0], bus.ATmPGH};
    p_edge   = sync_p_q[1] & ~sync_p_q[2];
    m_edge   = sync_m_q[1] & ~sync_m_q[2];

    edge_dt = '0;
    if (p_edge && !m_edge) begin
      edge_dt = One;
    end else if (m_edge && !p_edge) begin
      edge_dt = -One;
    end

    // A host load in a tick cycle swallows the whole service, pend included.
    service = tick & ~bus.cnt_we & (pend_q != '0);
    tick_dt = '0;
    if (service) begin
      tick_dt = pend_q[PEND_W-1] ? One : -One;
    end

    pend_ext  = PW'(pend_q);
    pend_sum  = pend_ext + edge_dt + tick_dt;
    pend_keep = pend_ext + tick_dt;
    // Saturation judged on the combined result; only the edge is ever dropped.
    ovf       = (edge_dt != '0) && ((pend_sum > PendHi) || (pend_sum < PendLo));

    pend_d = ovf ? pend_keep[PEND_W-1:0] : pend_sum[PEND_W-1:0];
    err_d  = err_q | ovf;

    cnt_d = cnt_q;
    if (bus.cnt_we) begin
      cnt_d = bus.cnt_wdata;
    end else if (service) begin
      cnt_d = pend_q[PEND_W-1] ? cnt_q - 15'd1 : cnt_q + 15'd1;
    end

    if (zero) begin
      cnt_d  = '0;
      pend_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      tick_q   <= '0;
      clockh_q <= 1'b0;
      mode_q   <= 3'b101;
      sync_p_q <= '0;
      sync_m_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      clockh_q <= clockh_d;
      mode_q   <= mode_d;
      sync_p_q <= sync_p_d;
      sync_m_q <= sync_m_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign bus.CLOCKH   = clockh_q;
  assign bus.AGCCA    = mode_q[0];
  assign bus.AGCZ     = mode_q[1];
  assign bus.AGCEEC   = mode_q[2];
  assign bus.cnt      = cnt_q;
  assign bus.pend_err = err_q;

endmodule
